// File: rtl/olink_seq_pkg.sv
// rtl/olink_seq_pkg.sv - state encoding and counter widths for the optical link sequencer
package olink_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_QPLL   = 3'd1,
    ST_WAIT_QPLL  = 3'd2,
    ST_WAIT_TXCLK = 3'd3,
    ST_WAIT_MMCM  = 3'd4,
    ST_WAIT_RX    = 3'd5,
    ST_LINK_UP    = 3'd6,
    ST_FAILED     = 3'd7
  } seq_state_t;

  localparam int RETRY_W = 4;
  localparam int DROP_W  = 16;

  // Reset levels held in each state, packed as {qpll, mmcm, gt_tx, gt_rx}.
  function automatic logic [3:0] reset_levels(input seq_state_t s);
    case (s)
      ST_WAIT_QPLL:  reset_levels = 4'b0111;
      ST_WAIT_TXCLK: reset_levels = 4'b0101;
      ST_WAIT_MMCM:  reset_levels = 4'b0001;
      ST_WAIT_RX,
      ST_LINK_UP:    reset_levels = 4'b0000;
      default:       reset_levels = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/olink_seq_sync.sv
// rtl/olink_seq_sync.sv - two-flop synchronizer for one asynchronous status bit
module olink_seq_sync (
  input  logic sysClk125,
  input  logic sysClk125Rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sysClk125) begin
    if (sysClk125Rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/olink_link_sequencer.sv
// rtl/olink_link_sequencer.sv - QPLL/GT/MMCM reset sequencing, RX alignment check and link-loss recovery
module olink_link_sequencer
  import olink_seq_pkg::*;
#(
  parameter int QPLL_RST_CYCLES = 64,
  parameter int MMCM_RST_CYCLES = 32,
  parameter int LOCK_TIMEOUT    = 125000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRIES     = 7
) (
  input  logic              sysClk125,
  input  logic              sysClk125Rst,
  input  logic              enable,
  input  logic              restart,
  input  logic              qpll_lock,
  input  logic              qpll_refclklost,
  input  logic              clk_link_lock,
  input  logic              rx_valid,
  output logic              qpll_reset,
  output logic              mmcm_reset,
  output logic              gt_tx_reset,
  output logic              gt_rx_reset,
  output logic              link_up,
  output logic              link_failed,
  output logic [2:0]        state,
  output logic [RETRY_W-1:0] retry_count,
  output logic [DROP_W-1:0]  link_drop_count
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_AT = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] QPLL_LAST  = TW'(QPLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] MMCM_LAST  = TW'(MMCM_RST_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic qpll_lock_s, qpll_refclklost_s, clk_link_lock_s, rx_valid_s;

  olink_seq_sync u_sync_qpll_lock (.sysClk125(sysClk125), .sysClk125Rst(sysClk125Rst), .d(qpll_lock),       .q(qpll_lock_s));
  olink_seq_sync u_sync_refclk    (.sysClk125(sysClk125), .sysClk125Rst(sysClk125Rst), .d(qpll_refclklost), .q(qpll_refclklost_s));
  olink_seq_sync u_sync_mmcm_lock (.sysClk125(sysClk125), .sysClk125Rst(sysClk125Rst), .d(clk_link_lock),   .q(clk_link_lock_s));
  olink_seq_sync u_sync_rx_valid  (.sysClk125(sysClk125), .sysClk125Rst(sysClk125Rst), .d(rx_valid),        .q(rx_valid_s));

  seq_state_t           state_q, state_d;
  logic [TW-1:0]        timer_q;
  logic [SW-1:0]        stab_q;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic                 timer_clr;
  logic                 take_timeout;

  logic timeout, stab_done, status_ok;
  assign timeout   = (timer_q == TIMEOUT_AT);
  assign stab_done = rx_valid_s && (stab_q == STAB_LAST);
  assign status_ok = qpll_lock_s && !qpll_refclklost_s && clk_link_lock_s && rx_valid_s;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    drop_d       = drop_q;
    timer_clr    = 1'b0;
    take_timeout = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else if (restart) begin
      state_d   = ST_RST_QPLL;
      retry_d   = '0;
      timer_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:       state_d = ST_RST_QPLL;
        ST_RST_QPLL:   if (timer_q == QPLL_LAST) state_d = ST_WAIT_QPLL;
        ST_WAIT_QPLL:  if (qpll_lock_s && !qpll_refclklost_s) state_d = ST_WAIT_TXCLK;
                       else if (timeout) take_timeout = 1'b1;
        ST_WAIT_TXCLK: if (timer_q == MMCM_LAST) state_d = ST_WAIT_MMCM;
        ST_WAIT_MMCM:  if (clk_link_lock_s) state_d = ST_WAIT_RX;
                       else if (timeout) take_timeout = 1'b1;
        ST_WAIT_RX:    if (stab_done) state_d = ST_LINK_UP;
                       else if (timeout) take_timeout = 1'b1;
        ST_LINK_UP: begin
          if (!status_ok) begin
            drop_d  = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
            retry_d = '0;
            state_d = ST_RST_QPLL;
          end
        end
        ST_FAILED:     state_d = ST_FAILED;
        default:       state_d = ST_IDLE;
      endcase
      // Forward progress beats a timeout landing on the same cycle.
      if (take_timeout) begin
        if (retry_q == RETRY_LIMIT) begin
          state_d = ST_FAILED;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ST_RST_QPLL;
        end
      end
    end
  end

  always_ff @(posedge sysClk125) begin
    if (sysClk125Rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      drop_q      <= '0;
      {qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset} <= 4'b1111;
      link_up     <= 1'b0;
      link_failed <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      if (timer_clr || (state_d != state_q)) timer_q <= '0;
      else if (timer_q != TIMER_MAX)         timer_q <= timer_q + TW'(1);
      if ((state_q == ST_WAIT_RX) && (state_d == ST_WAIT_RX) && rx_valid_s) stab_q <= stab_q + SW'(1);
      else                                                                   stab_q <= '0;
      // Outputs come from the next state so they line up with the state register.
      {qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset} <= reset_levels(state_d);
      link_up     <= (state_d == ST_LINK_UP);
      link_failed <= (state_d == ST_FAILED);
    end
  end

  assign state           = state_q;
  assign retry_count     = retry_q;
  assign link_drop_count = drop_q;

endmodule

// File: tb/tb_olink_link_sequencer.sv
// tb/tb_olink_link_sequencer.sv - directed self-checking bench for olink_link_sequencer
module tb_olink_link_sequencer;

  logic        sysClk125 = 1'b0;
  logic        sysClk125Rst;
  logic        enable, restart;
  logic        qpll_lock, qpll_refclklost, clk_link_lock, rx_valid;
  logic        qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset;
  logic        link_up, link_failed;
  logic [2:0]  state;
  logic [3:0]  retry_count;
  logic [15:0] link_drop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 sysClk125 = ~sysClk125;

  olink_link_sequencer #(
    .QPLL_RST_CYCLES(4), .MMCM_RST_CYCLES(4), .LOCK_TIMEOUT(100),
    .STABLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .sysClk125(sysClk125), .sysClk125Rst(sysClk125Rst), .enable(enable), .restart(restart),
    .qpll_lock(qpll_lock), .qpll_refclklost(qpll_refclklost), .clk_link_lock(clk_link_lock),
    .rx_valid(rx_valid), .qpll_reset(qpll_reset), .mmcm_reset(mmcm_reset),
    .gt_tx_reset(gt_tx_reset), .gt_rx_reset(gt_rx_reset), .link_up(link_up),
    .link_failed(link_failed), .state(state), .retry_count(retry_count),
    .link_drop_count(link_drop_count)
  );

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge sysClk125);
      n++;
    end
    n_cmp++;
    if (state !== s) begin
      n_fail++;
      $display("FAIL %s: state=%0d required=%0d after %0d cycles", name, state, s, n);
    end
  endtask

  task automatic wait_retry(input logic [3:0] r, input int budget, input string name);
    int n = 0;
    while (retry_count !== r && n < budget) begin
      @(negedge sysClk125);
      n++;
    end
    n_cmp++;
    if (retry_count !== r || state !== 3'd1) begin
      n_fail++;
      $display("FAIL %s: retry=%0d state=%0d required retry=%0d state=1", name, retry_count, state, r);
    end
  endtask

  task automatic test_reset();
    sysClk125Rst = 1'b1; enable = 1'b0; restart = 1'b0;
    qpll_lock = 1'b0; qpll_refclklost = 1'b0; clk_link_lock = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge sysClk125);
    n_cmp++;
    if ({state, qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset, link_up, link_failed, retry_count, link_drop_count}
        !== {3'd0, 4'hF, 2'b00, 4'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d rst=%b up=%b fail=%b retry=%0d drops=%0d required 0/1111/0/0/0/0",
               state, {qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset}, link_up, link_failed, retry_count, link_drop_count);
    end
    sysClk125Rst = 1'b0;
    @(negedge sysClk125);
    n_cmp++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_while_disabled: state=%0d required=0", state);
    end
  endtask

  task automatic test_clean_bringup();
    int dwell[8];
    logic [2:0] seqv[$];
    logic [2:0] exp_seq[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [2:0] prev = 3'd0;
    logic [3:0] exp_rst;
    int t_rx = -1, t_up = -1, dec_err = 0;
    for (int i = 0; i < 8; i++) dwell[i] = 0;
    qpll_lock = 1'b1; clk_link_lock = 1'b1; rx_valid = 1'b0;
    repeat (3) @(negedge sysClk125);
    enable = 1'b1;
    for (int c = 0; c < 200 && state !== 3'd6; c++) begin
      @(negedge sysClk125);
      if (state !== prev) seqv.push_back(state);
      prev = state;
      dwell[state]++;
      case (state)
        3'd2:         exp_rst = 4'b0111;
        3'd3:         exp_rst = 4'b0101;
        3'd4:         exp_rst = 4'b0001;
        3'd5, 3'd6:   exp_rst = 4'b0000;
        default:      exp_rst = 4'b1111;
      endcase
      if ({qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset} !== exp_rst) dec_err++;
      if (state === 3'd5 && rx_valid === 1'b0) begin rx_valid = 1'b1; t_rx = c; end
      if (link_up === 1'b1 && t_up < 0) t_up = c;
    end
    n_cmp++;
    if (seqv.size() != 6) begin
      n_fail++;
      $display("FAIL bringup_seq_len: got %0d states required 6", seqv.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (seqv[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL bringup_seq[%0d]: state=%0d required=%0d", i, seqv[i], exp_seq[i]);
        end
      end
    end
    n_cmp++;
    if (dwell[1] != 4 || dwell[3] != 4) begin
      n_fail++;
      $display("FAIL fixed_dwell: rst_qpll=%0d wait_txclk=%0d required 4/4", dwell[1], dwell[3]);
    end
    n_cmp++;
    if (dec_err != 0) begin
      n_fail++;
      $display("FAIL reset_decode: %0d cycles with wrong reset levels, required 0", dec_err);
    end
    n_cmp++;
    if (t_up - t_rx != 10 || t_rx < 0) begin
      n_fail++;
      $display("FAIL linkup_latency: %0d cycles required 10", t_up - t_rx);
    end
  endtask

  task automatic test_drop_while_up();
    clk_link_lock = 1'b0;
    @(negedge sysClk125);
    clk_link_lock = 1'b1;
    @(negedge sysClk125);
    n_cmp++;
    if (link_up !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_early: link_up=%b required=1", link_up);
    end
    @(negedge sysClk125);
    n_cmp++;
    if ({link_up, state, retry_count, link_drop_count} !== {1'b0, 3'd1, 4'd0, 16'd1}) begin
      n_fail++;
      $display("FAIL drop_exit: up=%b state=%0d retry=%0d drops=%0d required 0/1/0/1",
               link_up, state, retry_count, link_drop_count);
    end
    wait_state(3'd6, 100, "drop_relock");
  endtask

  task automatic test_unstable_rx();
    int d = 0;
    enable = 1'b0;
    @(negedge sysClk125);
    n_cmp++;
    if ({state, link_up, link_drop_count} !== {3'd0, 1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL disable_idle: state=%0d up=%b drops=%0d required 0/0/1", state, link_up, link_drop_count);
    end
    rx_valid = 1'b0;
    enable = 1'b1;
    wait_state(3'd5, 100, "unstable_reach_rx");
    while (state === 3'd5 && d < 300) begin
      rx_valid = ((d % 6) != 5);
      @(negedge sysClk125);
      d++;
    end
    n_cmp++;
    if (d != 100 || state !== 3'd1 || retry_count !== 4'd1) begin
      n_fail++;
      $display("FAIL unstable_timeout: dwell=%0d state=%0d retry=%0d required 100/1/1", d, state, retry_count);
    end
  endtask

  task automatic test_qpll_never_locks();
    restart = 1'b1;
    qpll_lock = 1'b0;
    @(negedge sysClk125);
    restart = 1'b0;
    n_cmp++;
    if (state !== 3'd1 || retry_count !== 4'd0) begin
      n_fail++;
      $display("FAIL restart_clear: state=%0d retry=%0d required 1/0", state, retry_count);
    end
    wait_retry(4'd1, 300, "qpll_retry1");
    wait_retry(4'd2, 300, "qpll_retry2");
    wait_state(3'd7, 300, "qpll_failed");
    repeat (20) @(negedge sysClk125);
    n_cmp++;
    if ({state, link_failed, link_up, qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset} !== {3'd7, 1'b1, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL failed_hold: state=%0d failed=%b up=%b rst=%b required 7/1/0/1111",
               state, link_failed, link_up, {qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset});
    end
    restart = 1'b1;
    @(negedge sysClk125);
    restart = 1'b0;
    n_cmp++;
    if ({state, retry_count, link_failed} !== {3'd1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL failed_restart: state=%0d retry=%0d failed=%b required 1/0/0", state, retry_count, link_failed);
    end
  endtask

  task automatic test_saturation();
    qpll_lock = 1'b1; clk_link_lock = 1'b1; rx_valid = 1'b1;
    wait_state(3'd6, 100, "sat_linkup");
    force dut.drop_q = 16'hFFFE;
    repeat (2) @(negedge sysClk125);
    release dut.drop_q;
    for (int k = 0; k < 2; k++) begin
      clk_link_lock = 1'b0;
      @(negedge sysClk125);
      clk_link_lock = 1'b1;
      repeat (2) @(negedge sysClk125);
      n_cmp++;
      if (link_drop_count !== 16'hFFFF || state !== 3'd1) begin
        n_fail++;
        $display("FAIL saturate[%0d]: drops=%h state=%0d required ffff/1", k, link_drop_count, state);
      end
      wait_state(3'd6, 100, "sat_relock");
    end
  endtask

  task automatic test_precedence();
    clk_link_lock = 1'b0;
    restart = 1'b1;
    @(negedge sysClk125);
    restart = 1'b0;
    wait_state(3'd4, 100, "prec_reach_mmcm");
    enable = 1'b0;
    restart = 1'b1;
    @(negedge sysClk125);
    n_cmp++;
    if ({state, retry_count, qpll_reset, link_drop_count} !== {3'd0, 4'd0, 1'b1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL enable_over_restart: state=%0d retry=%0d qrst=%b drops=%h required 0/0/1/ffff",
               state, retry_count, qpll_reset, link_drop_count);
    end
    restart = 1'b0;
    enable = 1'b1;
    clk_link_lock = 1'b1;
    wait_state(3'd3, 100, "prec_reach_txclk");
    sysClk125Rst = 1'b1;
    @(negedge sysClk125);
    n_cmp++;
    if ({state, qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset, link_up, link_failed, retry_count, link_drop_count}
        !== {3'd0, 4'hF, 2'b00, 4'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: state=%0d rst=%b up=%b fail=%b retry=%0d drops=%h required 0/1111/0/0/0/0",
               state, {qpll_reset, mmcm_reset, gt_tx_reset, gt_rx_reset}, link_up, link_failed, retry_count, link_drop_count);
    end
    sysClk125Rst = 1'b0;
    @(negedge sysClk125);
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_drop_while_up();
    test_unstable_rx();
    test_qpll_never_locks();
    test_saturation();
    test_precedence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/olink_link_sequencer.md
# olink_link_sequencer

Bring-up and recovery controller for the optical DAQ link: sequences the QPLL reset, the GT TX/RX resets and the link-clock MMCM reset in the required order, and confirms RX word alignment before declaring the link up. It watches lock/valid status while the link is up and re-runs the sequence on any loss, with bounded retries and a sticky failure state. It sits beside the GTX link wrapper in the `sysClk125` domain and is controlled and observed through AXI-Lite register bits.

## Interface
- `QPLL_RST_CYCLES`, 64: cycles QPLL reset is held.
- `MMCM_RST_CYCLES`, 32: cycles MMCM reset is held after GT TX reset release.
- `LOCK_TIMEOUT`, 125000: max cycles in any wait state (1 ms at 125 MHz).
- `STABLE_CYCLES`, 1024: consecutive cycles `rx_valid` must be high before link-up.
- `MAX_RETRIES`, 7: timed-out attempts allowed before FAILED; max 15.
- `sysClk125` in 1: only clock.
- `sysClk125Rst` in 1: reset, synchronous, active-high.
- `enable` in 1: level; 0 forces IDLE.
- `restart` in 1: single-cycle pulse from an AXI register write.
- `qpll_lock` in 1: asynchronous.
- `qpll_refclklost` in 1: asynchronous.
- `clk_link_lock` in 1: asynchronous; MMCM locked.
- `rx_valid` in 1: asynchronous; `clk_link` domain.
- `qpll_reset` out 1.
- `mmcm_reset` out 1.
- `gt_tx_reset` out 1.
- `gt_rx_reset` out 1.
- `link_up` out 1.
- `link_failed` out 1.
- `state` out 3: current state encoding.
- `retry_count` out 4: timeouts in the current bring-up attempt.
- `link_drop_count` out 16: LINK_UP exits caused by status loss; saturating.

## Operation
- All four asynchronous inputs pass through 2-flop synchronizers. The suffix `_s` below means the synchronized value.
- Precedence each cycle: `sysClk125Rst` > `enable`=0 > `restart` > normal transitions.
- States and output levels. Resets listed are 1; unlisted resets are 0.
  - IDLE(0): all four resets. Go to RST_QPLL when `enable`=1.
  - RST_QPLL(1): all four resets. Go to WAIT_QPLL after exactly QPLL_RST_CYCLES cycles.
  - WAIT_QPLL(2): `mmcm_reset`, `gt_tx_reset`, `gt_rx_reset`. Go to WAIT_TXCLK when `qpll_lock_s`=1 and `qpll_refclklost_s`=0.
  - WAIT_TXCLK(3): `mmcm_reset`, `gt_rx_reset`. Go to WAIT_MMCM after exactly MMCM_RST_CYCLES cycles.
  - WAIT_MMCM(4): `gt_rx_reset`. Go to WAIT_RX when `clk_link_lock_s`=1.
  - WAIT_RX(5): no resets. Go to LINK_UP once `rx_valid_s` has been 1 for STABLE_CYCLES consecutive cycles. Any 0 restarts the stability count.
  - LINK_UP(6): no resets; `link_up`=1. Leaves on any of `qpll_lock_s`=0, `qpll_refclklost_s`=1, `clk_link_lock_s`=0, `rx_valid_s`=0. Exit action: `link_drop_count`++ (saturating at 0xFFFF), `retry_count`←0, go to RST_QPLL.
  - FAILED(7): all four resets; `link_failed`=1. Held until `restart` or `enable`=0.
- Timeout: the state timer reaches LOCK_TIMEOUT in WAIT_QPLL, WAIT_MMCM or WAIT_RX.
  - If `retry_count`==MAX_RETRIES: go to FAILED.
  - Otherwise: `retry_count`++ and go to RST_QPLL.
- `restart` (with `enable`=1, any state including FAILED): go to RST_QPLL; clear `retry_count` and the timer.
- `enable`=0: go to IDLE. `retry_count` is cleared; `link_drop_count` is kept.
- `link_drop_count` is cleared only by `sysClk125Rst`.

## Timing
- Reset values:
  - `state`=IDLE.
  - `qpll_reset`=`mmcm_reset`=`gt_tx_reset`=`gt_rx_reset`=1.
  - `link_up`=0, `link_failed`=0.
  - `retry_count`=0, `link_drop_count`=0.
  - Timer and stability counter = 0.
- Outputs are registered and decoded from the next state, so they always match `state` in the same cycle.
- State timer: cleared on every state entry and incremented once per cycle. A fixed-length state of N cycles exits when timer==N-1. Width is clog2(LOCK_TIMEOUT+1).
- Synchronizer latency: an input edge at cycle t is seen by the FSM at t+2, and the resulting state change appears at t+3.
- Status loss that coincides with a timeout or a stability completion: evaluated in state-priority order. In LINK_UP, loss always wins.

## Structure
- Package `olink_seq_pkg`: 3-bit state encoding constants, retry and drop counter widths.
- Sub-module `olink_seq_sync`: a 2-flop synchronizer, instantiated once per asynchronous input.
- FSM, timer, stability counter and statistics counters stay in the top level.

## Test plan
All scenarios use parameters 4/4/100/8/2 (QPLL_RST_CYCLES / MMCM_RST_CYCLES / LOCK_TIMEOUT / STABLE_CYCLES / MAX_RETRIES).
- Clean bring-up:
  - Stimulus: `enable`=1; `qpll_lock`, `clk_link_lock` and `rx_valid` rise promptly.
  - Response: state sequence 1→2→3→4→5→6. `qpll_reset` high for exactly 4 cycles. `link_up`=1 exactly 8 cycles plus sync latency after `rx_valid_s` first goes high.
- QPLL never locks:
  - Stimulus: `qpll_lock` held at 0.
  - Response: `retry_count` goes 1, then 2, then FAILED (7) with `link_failed`=1 and all resets high. The state stays 7 until `restart`, after which `retry_count`=0 and `state`=1.
- Unstable RX:
  - Stimulus: `rx_valid` toggles low every 6 cycles.
  - Response: no LINK_UP; timeout after 100 cycles, then `retry_count`=1.
- Drop while up:
  - Stimulus: in LINK_UP, pull `clk_link_lock` low for 1 cycle.
  - Response: `link_drop_count`=1, `link_up` falls 3 cycles later, `state`=1, `retry_count`=0. Re-locks normally.
- Precedence:
  - Stimulus: `enable`=0 together with `restart` in WAIT_MMCM.
  - Response: IDLE next cycle. Then `sysClk125Rst` mid-sequence returns every output to its reset value, including `link_drop_count`=0.
- Saturation:
  - Stimulus: force 65,536 drops (e.g. `link_drop_count` preloaded to 0xFFFE by force).
  - Response: the counter stops at 0xFFFF.
